// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and small decode helpers.
package md_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation. Used to take operand magnitudes at
// start and to restore result signs once the unsigned iteration is finished.
module md_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Negate when requested, otherwise pass through unchanged.
   always_comb begin
      dout = neg ? (~din + ONE) : din;
   end

endmodule

// File: rtl/md_unit_iter.sv
// Iterative multiply/divide unit holding the HI/LO pair. Operands are reduced
// to magnitudes at start, WIDTH radix-2 steps run on unsigned values, and the
// FIX state restores signs and writes HI/LO.
// Handshake: start is accepted only while busy is low (state IDLE); busy stays
// high until the edge on which done pulses for one cycle with HI/LO updated.
module md_unit_iter
   import md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   dv_q, dv_d;        // multiplicand (mul) or divisor (div)
   logic [WIDTH-1:0]   aorig_q, aorig_d;  // raw dividend, returned in HI on /0
   logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or {remainder, quotient}
   logic               neg_q, neg_d;      // negate product / quotient
   logic               rneg_q, rneg_d;    // negate remainder
   logic               bz_q, bz_d;        // divisor was zero
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               start_signed;
   logic [WIDTH-1:0]   abs_a, abs_b, quot_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     mul_sum, div_trial, div_diff;
   logic               div_ge;

   assign start_signed = op_is_signed(op);

   md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
      .neg  (start_signed & a[WIDTH-1]),
      .din  (a),
      .dout (abs_a)
   );

   md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
      .neg  (start_signed & b[WIDTH-1]),
      .din  (b),
      .dout (abs_b)
   );

   md_sign_fix #(.WIDTH(2*WIDTH)) u_prod_fix (
      .neg  (neg_q),
      .din  (acc_q),
      .dout (prod_fix)
   );

   md_sign_fix #(.WIDTH(WIDTH)) u_quot_fix (
      .neg  (neg_q),
      .din  (acc_q[WIDTH-1:0]),
      .dout (quot_fix)
   );

   md_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
      .neg  (rneg_q),
      .din  (acc_q[2*WIDTH-1:WIDTH]),
      .dout (rem_fix)
   );

   // One radix-2 step: shift-add for multiply, restoring trial subtract for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, dv_q} : {(WIDTH+1){1'b0}});
      div_trial = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_trial - {1'b0, dv_q};
      div_ge    = ~div_diff[WIDTH];
   end

   // Controller next state, operand capture, iteration and result write-back.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      dv_d    = dv_q;
      aorig_d = aorig_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      bz_d    = bz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = dz_q;

      case (state_q)
         ST_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               state_d = ST_CALC;
               op_d    = op;
               cnt_d   = '0;
               dz_d    = 1'b0;
               aorig_d = a;
               neg_d   = start_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               rneg_d  = start_signed & a[WIDTH-1];
               bz_d    = op_is_div(op) && (b == '0);
               if (op_is_div(op)) begin
                  dv_d  = abs_b;
                  acc_d = {{WIDTH{1'b0}}, abs_a};
               end else begin
                  dv_d  = abs_a;
                  acc_d = {{WIDTH{1'b0}}, abs_b};
               end
            end
         end

         ST_CALC: begin
            if (op_is_div(op_q)) begin
               acc_d = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                              : {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_STEP) state_d = ST_FIX;
         end

         ST_FIX: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            dz_d    = bz_q;
            if (op_is_div(op_q)) begin
               if (bz_q) begin
                  lo_d = '1;
                  hi_d = aorig_q;
               end else begin
                  lo_d = quot_fix;
                  hi_d = rem_fix;
               end
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         dv_q    <= '0;
         aorig_q <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         bz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         dv_q    <= dv_d;
         aorig_q <= aorig_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         bz_q    <= bz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign dz        = dz_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbg_state = state_q;

endmodule
